glitch_sweep_ctrl: RTL and testbench
====================================

// Module: glitch_sweep_ctrl
// PURPOSE
//  Sequencer for the glitch pulse generator. Sweeps holdoff (outer loop) and pulse_width
//  (inner loop) over programmed ranges with N repeats per point. Per attempt: optionally
//  waits for a target trigger edge, arms the generator, waits for its rdy, then cools down.
//  Sits between the host config registers and the glitch generator's armed/holdoff/pulse_width/rdy pins.
// PARAMETERS
//  W            32  width of holdoff/width/step/cooldown/count values
//  SYNC_STAGES  2   flops in trigger synchroniser (>=2)
// PORTS
//  clk           in   1  system clock (single clock domain)
//  rst_n         in   1  asynchronous active-low reset
//  start         in   1  1-cycle pulse: latch config, begin sweep (ignored while busy)
//  abort         in   1  level/pulse: stop sweep, return to IDLE
//  use_trigger   in   1  1: each attempt waits for trigger rising edge; 0: arm immediately
//  trigger       in   1  asynchronous target trigger
//  ho_start/ho_end/ho_step  in W  holdoff sweep range and step
//  pw_start/pw_end/pw_step  in W  pulse_width sweep range and step
//  repeats       in   W  attempts per (holdoff,width) point; 0 treated as 1
//  cooldown      in   W  idle cycles between attempts; 0 treated as 1
//  glitch_rdy    in   1  rdy from glitch generator
//  armed         out  1  to glitch generator
//  holdoff       out  W  to glitch generator, stable whenever armed=1
//  pulse_width   out  W  to glitch generator, stable whenever armed=1
//  busy          out  1  high from cycle after accepted start until IDLE
//  done          out  1  1-cycle pulse on normal sweep completion (not on abort)
//  attempt_stb   out  1  1-cycle pulse per completed attempt
//  attempt_cnt   out  W  completed attempts since start; wraps at 2^W
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; config registers 0.
//  Config latched on accepted start; later changes to config inputs ignored until next start.
//  States: IDLE -> WAIT_TRIG -> FIRE -> COOL -> STEP -> (WAIT_TRIG | DONE) -> IDLE.
//   IDLE: on start: holdoff<=ho_start, pulse_width<=pw_start, rep<=0, attempt_cnt<=0, ->WAIT_TRIG.
//   WAIT_TRIG: use_trigger=0 -> FIRE next cycle; else wait synchronised rising edge.
//     Edge detector primed on WAIT_TRIG entry: a trigger already high must fall and rise again.
//   FIRE: armed=1 (registered; asserted first cycle in FIRE). Stay until glitch_rdy=1,
//     then armed<=0, attempt_stb<=1, attempt_cnt++, ->COOL.
//   COOL: count max(cooldown,1) cycles AND glitch_rdy==0 before leaving (no re-arm on stale rdy).
//   STEP: rep+1 < max(repeats,1): rep++. Else rep<=0 and advance pulse_width; if width
//     exhausted, pulse_width<=pw_start and advance holdoff; if holdoff exhausted -> DONE.
//     Otherwise -> WAIT_TRIG.
//   DONE: done=1 for one cycle, busy drops same cycle, ->IDLE.
//  Advance rule (each axis): next = cur+step computed W+1 bits; axis exhausted if step==0,
//   carry out, or next > end. start>end => single point at start. Values never wrap.
//  abort (any non-IDLE state): next cycle armed=0, busy=0, state IDLE, no done,
//   holdoff/pulse_width/attempt_cnt hold last values. abort and start same cycle in IDLE: abort wins.
//  armed is never high in two consecutive attempts without >=1 cycle low between.
//  Latency: start->armed = 2 cycles (use_trigger=0); trigger edge->armed = SYNC_STAGES+2 cycles.
// STRUCTURE
//  Package glitch_pkg: W default, state enum (IDLE,WAIT_TRIG,FIRE,COOL,STEP,DONE),
//   SYNC_STAGES default.
//  Sub-module: glitch_trig_sync (SYNC_STAGES flop synchroniser + rising-edge detect with
//   prime input); remainder in one FSM + counters.
// TESTING
//  1 ho 10..30 step 10, pw 1..3 step 1, repeats=1, no trigger -> 9 attempts in order
//    (10,1)(10,2)(10,3)(20,1)..(30,3); attempt_cnt=9; one done pulse.
//  2 repeats=3, single point (5,2) -> 3 armed windows, each separated by >=cooldown low cycles.
//  3 use_trigger=1, trigger held high at start -> no arm until low then high; armed at edge+SYNC_STAGES+2.
//  4 ho_start=0xFFFFFFF0, step 0x20, end 0xFFFFFFFF -> single holdoff point, no wrap, done.
//  5 abort while armed (glitch_rdy=0) -> armed=0, busy=0 next cycle, no done; new start works.
//  6 glitch_rdy stuck 1 after first attempt -> stays in COOL, no second arm until rdy drops.

Source files
------------

// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch sweep sequencer: default widths and FSM states.
package glitch_pkg;

  localparam int GLITCH_W           = 32;
  localparam int GLITCH_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TRIG = 3'd1,
    FIRE      = 3'd2,
    COOL      = 3'd3,
    STEP      = 3'd4,
    DONE      = 3'd5
  } state_e;

endpackage

// File: rtl/glitch_trig_sync.sv
// Trigger synchroniser plus registered rising-edge detector.
// 'prime' forgets the current level: a trigger that is already high must
// fall and rise again before 'rise' pulses.
module glitch_trig_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_async,
  input  logic prime,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;

  genvar gi;

  // Shift chain: stage 0 samples the pin, each later stage copies its predecessor.
  assign sync_d[0] = trig_async;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate

  // Edge detect on the synchronised level; priming pretends the last level was high.
  always_comb begin
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    if (prime) begin
      prev_d = 1'b1;
      rise_d = 1'b0;
    end
  end

  // State registers for the synchroniser and detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/glitch_sweep_ctrl.sv
// Glitch sweep sequencer: walks holdoff (outer) x pulse_width (inner) with
// a repeat count per point, arming the glitch generator once per attempt.
module glitch_sweep_ctrl
  import glitch_pkg::*;
#(
  parameter int W           = GLITCH_W,
  parameter int SYNC_STAGES = GLITCH_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         use_trigger,
  input  logic         trigger,
  input  logic [W-1:0] ho_start,
  input  logic [W-1:0] ho_end,
  input  logic [W-1:0] ho_step,
  input  logic [W-1:0] pw_start,
  input  logic [W-1:0] pw_end,
  input  logic [W-1:0] pw_step,
  input  logic [W-1:0] repeats,
  input  logic [W-1:0] cooldown,
  input  logic         glitch_rdy,
  output logic         armed,
  output logic [W-1:0] holdoff,
  output logic [W-1:0] pulse_width,
  output logic         busy,
  output logic         done,
  output logic         attempt_stb,
  output logic [W-1:0] attempt_cnt
);

  localparam logic [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   ONE_X = {{W{1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [W-1:0] holdoff_q, holdoff_d;
  logic [W-1:0] pulse_width_q, pulse_width_d;
  logic [W-1:0] rep_q, rep_d;
  logic [W-1:0] attempt_cnt_q, attempt_cnt_d;
  logic [W-1:0] cool_cnt_q, cool_cnt_d;
  logic         armed_q, armed_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         attempt_stb_q, attempt_stb_d;

  // Configuration snapshot taken at start; repeat/cooldown stored already clamped to >=1.
  logic         cfg_use_trig_q, cfg_use_trig_d;
  logic [W-1:0] cfg_ho_end_q, cfg_ho_end_d;
  logic [W-1:0] cfg_ho_step_q, cfg_ho_step_d;
  logic [W-1:0] cfg_pw_start_q, cfg_pw_start_d;
  logic [W-1:0] cfg_pw_end_q, cfg_pw_end_d;
  logic [W-1:0] cfg_pw_step_q, cfg_pw_step_d;
  logic [W-1:0] cfg_rep_tgt_q, cfg_rep_tgt_d;
  logic [W-1:0] cfg_cool_tgt_q, cfg_cool_tgt_d;

  logic [W:0]   ho_next, pw_next;
  logic         ho_exh, pw_exh, rep_more, cool_done;
  logic         prime, trig_rise;

  // Axis advance is done one bit wider so a carry marks the axis exhausted instead of wrapping.
  assign ho_next   = {1'b0, holdoff_q} + {1'b0, cfg_ho_step_q};
  assign pw_next   = {1'b0, pulse_width_q} + {1'b0, cfg_pw_step_q};
  assign ho_exh    = (cfg_ho_step_q == '0) || ho_next[W] || (ho_next[W-1:0] > cfg_ho_end_q);
  assign pw_exh    = (cfg_pw_step_q == '0) || pw_next[W] || (pw_next[W-1:0] > cfg_pw_end_q);
  assign rep_more  = ({1'b0, rep_q} + ONE_X) < {1'b0, cfg_rep_tgt_q};
  assign cool_done = cool_cnt_q >= (cfg_cool_tgt_q - ONE);

  glitch_trig_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_trig_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig_async(trigger),
    .prime     (prime),
    .rise      (trig_rise)
  );

  // Next-state, counter and registered-output logic for the sweep FSM.
  always_comb begin
    state_d        = state_q;
    holdoff_d      = holdoff_q;
    pulse_width_d  = pulse_width_q;
    rep_d          = rep_q;
    attempt_cnt_d  = attempt_cnt_q;
    cool_cnt_d     = cool_cnt_q;
    attempt_stb_d  = 1'b0;
    cfg_use_trig_d = cfg_use_trig_q;
    cfg_ho_end_d   = cfg_ho_end_q;
    cfg_ho_step_d  = cfg_ho_step_q;
    cfg_pw_start_d = cfg_pw_start_q;
    cfg_pw_end_d   = cfg_pw_end_q;
    cfg_pw_step_d  = cfg_pw_step_q;
    cfg_rep_tgt_d  = cfg_rep_tgt_q;
    cfg_cool_tgt_d = cfg_cool_tgt_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          cfg_use_trig_d = use_trigger;
          cfg_ho_end_d   = ho_end;
          cfg_ho_step_d  = ho_step;
          cfg_pw_start_d = pw_start;
          cfg_pw_end_d   = pw_end;
          cfg_pw_step_d  = pw_step;
          cfg_rep_tgt_d  = (repeats == '0) ? ONE : repeats;
          cfg_cool_tgt_d = (cooldown == '0) ? ONE : cooldown;
          holdoff_d      = ho_start;
          pulse_width_d  = pw_start;
          rep_d          = '0;
          attempt_cnt_d  = '0;
          state_d        = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (!cfg_use_trig_q || trig_rise) state_d = FIRE;
      end
      FIRE: begin
        if (glitch_rdy) begin
          attempt_stb_d = 1'b1;
          attempt_cnt_d = attempt_cnt_q + ONE;
          cool_cnt_d    = '0;
          state_d       = COOL;
        end
      end
      COOL: begin
        // Leave only once the full cooldown has elapsed and the generator has dropped rdy.
        if (cool_done) begin
          if (!glitch_rdy) state_d = STEP;
        end else begin
          cool_cnt_d = cool_cnt_q + ONE;
        end
      end
      STEP: begin
        state_d = WAIT_TRIG;
        if (rep_more) begin
          rep_d = rep_q + ONE;
        end else begin
          rep_d = '0;
          if (!pw_exh) begin
            pulse_width_d = pw_next[W-1:0];
          end else begin
            pulse_width_d = cfg_pw_start_q;
            if (!ho_exh) holdoff_d = ho_next[W-1:0];
            else         state_d   = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE; sweep position and count freeze as they were.
    if (abort && state_q != IDLE) begin
      state_d       = IDLE;
      holdoff_d     = holdoff_q;
      pulse_width_d = pulse_width_q;
      rep_d         = rep_q;
      attempt_cnt_d = attempt_cnt_q;
      cool_cnt_d    = cool_cnt_q;
      attempt_stb_d = 1'b0;
    end

    armed_d = (state_d == FIRE);
    busy_d  = (state_d != IDLE) && (state_d != DONE);
    done_d  = (state_d == DONE);
    prime   = (state_d == WAIT_TRIG) && (state_q != WAIT_TRIG);
  end

  // State, counter and configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      holdoff_q      <= '0;
      pulse_width_q  <= '0;
      rep_q          <= '0;
      attempt_cnt_q  <= '0;
      cool_cnt_q     <= '0;
      armed_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      attempt_stb_q  <= 1'b0;
      cfg_use_trig_q <= 1'b0;
      cfg_ho_end_q   <= '0;
      cfg_ho_step_q  <= '0;
      cfg_pw_start_q <= '0;
      cfg_pw_end_q   <= '0;
      cfg_pw_step_q  <= '0;
      cfg_rep_tgt_q  <= '0;
      cfg_cool_tgt_q <= '0;
    end else begin
      state_q        <= state_d;
      holdoff_q      <= holdoff_d;
      pulse_width_q  <= pulse_width_d;
      rep_q          <= rep_d;
      attempt_cnt_q  <= attempt_cnt_d;
      cool_cnt_q     <= cool_cnt_d;
      armed_q        <= armed_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      attempt_stb_q  <= attempt_stb_d;
      cfg_use_trig_q <= cfg_use_trig_d;
      cfg_ho_end_q   <= cfg_ho_end_d;
      cfg_ho_step_q  <= cfg_ho_step_d;
      cfg_pw_start_q <= cfg_pw_start_d;
      cfg_pw_end_q   <= cfg_pw_end_d;
      cfg_pw_step_q  <= cfg_pw_step_d;
      cfg_rep_tgt_q  <= cfg_rep_tgt_d;
      cfg_cool_tgt_q <= cfg_cool_tgt_d;
    end
  end

  assign armed       = armed_q;
  assign holdoff     = holdoff_q;
  assign pulse_width = pulse_width_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign attempt_stb = attempt_stb_q;
  assign attempt_cnt = attempt_cnt_q;

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Bench for glitch_sweep_ctrl: directed corner sweeps plus random sweeps,
// with a scoreboard of expected attempts built from the sweep rules.
`timescale 1ns/1ps
module tb_glitch_sweep_ctrl;

  localparam int SYNC = 2;
  localparam int WAIT_LIMIT = 30000;

  typedef struct {
    logic [31:0] ho;
    logic [31:0] pw;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, use_trigger, trigger, glitch_rdy;
  logic [31:0] ho_start, ho_end, ho_step, pw_start, pw_end, pw_step, repeats, cooldown;
  logic        armed, busy, done, attempt_stb;
  logic [31:0] holdoff, pulse_width, attempt_cnt;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_done = 0;
  int   act_done = 0;
  int   cur_cool = 1;
  int   rdy_mode = 0;     // 0: answer each arm, 1: never answer, 2: hold rdy high
  logic trig_auto = 1'b0;
  logic trig_cmd = 1'b0;

  glitch_sweep_ctrl #(.W(32), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .use_trigger(use_trigger), .trigger(trigger),
    .ho_start(ho_start), .ho_end(ho_end), .ho_step(ho_step),
    .pw_start(pw_start), .pw_end(pw_end), .pw_step(pw_step),
    .repeats(repeats), .cooldown(cooldown), .glitch_rdy(glitch_rdy),
    .armed(armed), .holdoff(holdoff), .pulse_width(pulse_width),
    .busy(busy), .done(done), .attempt_stb(attempt_stb), .attempt_cnt(attempt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: enumerate every attempt of the sweep with plain wide arithmetic.
  task automatic push_model(input logic [31:0] hs, he, hst, ps, pe, pst, rep);
    longint unsigned h, p;
    int              nrep;
    exp_t            e;
    logic [31:0]     cnt;
    cnt  = 0;
    nrep = (rep == 0) ? 1 : int'(rep);
    h    = hs;
    forever begin
      p = ps;
      forever begin
        for (int k = 0; k < nrep; k++) begin
          cnt++;
          e.ho = h[31:0]; e.pw = p[31:0]; e.cnt = cnt;
          exp_q.push_back(e);
        end
        if (pst == 0 || p + pst > pe) break;
        p = p + pst;
      end
      if (hst == 0 || h + hst > he) break;
      h = h + hst;
    end
  endtask

  task automatic set_cfg(input logic [31:0] hs, he, hst, ps, pe, pst, rep, cool, input logic ut);
    ho_start = hs; ho_end = he; ho_step = hst;
    pw_start = ps; pw_end = pe; pw_step = pst;
    repeats = rep; cooldown = cool; use_trigger = ut;
    cur_cool = (cool == 0) ? 1 : int'(cool);
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic scramble_cfg();
    ho_start = $urandom; ho_end = $urandom; ho_step = $urandom;
    pw_start = $urandom; pw_end = $urandom; pw_step = $urandom;
    repeats = $urandom; cooldown = $urandom; use_trigger = $urandom_range(0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < WAIT_LIMIT) begin cycle(); n++; end
    chk({tag, "_finish_in_time"}, 64'(n < WAIT_LIMIT), 1);
    cycle(); cycle();
  endtask

  task automatic run_sweep(input string tag);
    push_model(ho_start, ho_end, ho_step, pw_start, pw_end, pw_step, repeats);
    exp_done++;
    start = 1'b1; cycle(); start = 1'b0;
    chk({tag, "_busy_after_start"}, busy, 1);
    scramble_cfg();
    wait_idle(tag);
  endtask

  // Glitch generator stand-in: answers an arm with a one-cycle rdy after a random wait.
  initial begin
    int wait_n;
    wait_n = 0;
    glitch_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (rdy_mode == 2) glitch_rdy = 1'b1;
      else if (glitch_rdy) glitch_rdy = 1'b0;
      else if (armed && rdy_mode == 0) begin
        if (wait_n <= 0) begin glitch_rdy = 1'b1; wait_n = $urandom_range(0, 3); end
        else wait_n--;
      end
    end
  end

  // Trigger source: follows trig_cmd, or toggles at random when trig_auto is set.
  initial begin
    int hold_n;
    hold_n = 0;
    trigger = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (trig_auto) begin
        if (hold_n <= 0) begin trigger = ~trigger; hold_n = $urandom_range(1, 6); end
        else hold_n--;
      end else begin
        trigger = trig_cmd;
      end
    end
  end

  // Monitor: scoreboard pops on attempt_stb, plus done, arm-window and gap checks.
  initial begin
    exp_t        e;
    logic [31:0] rec_ho, rec_pw;
    logic        moved, have_prev, prev_armed;
    int          gap;
    moved = 0; have_prev = 0; prev_armed = 0; gap = 0; rec_ho = 0; rec_pw = 0;
    forever begin
      @(negedge clk);
      if (attempt_stb === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("attempt_expected", 64'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          $display("attempt %0d: holdoff=0x%0h pulse_width=0x%0h", attempt_cnt, holdoff, pulse_width);
          chk("attempt_holdoff", holdoff, e.ho);
          chk("attempt_pulse_width", pulse_width, e.pw);
          chk("attempt_cnt", attempt_cnt, e.cnt);
        end
      end
      if (done === 1'b1) begin
        act_done++;
        $display("sweep done after %0d attempts", attempt_cnt);
        chk("busy_low_with_done", busy, 0);
        chk("no_attempts_left_at_done", 64'(exp_q.size()), 0);
      end
      if (armed && !prev_armed) begin
        rec_ho = holdoff; rec_pw = pulse_width; moved = 0;
        if (have_prev) chk("armed_gap_ge_cooldown", 64'(gap >= cur_cool), 1);
      end else if (armed) begin
        if (holdoff !== rec_ho || pulse_width !== rec_pw) moved = 1;
      end
      if (!armed && prev_armed) begin
        chk("armed_values_stable", moved, 0);
        have_prev = 1; gap = 0;
      end
      if (!armed) gap++;
      if (!busy && !armed) have_prev = 0;
      prev_armed = armed;
    end
  end

  // Stimulus: directed corners first, then random sweeps.
  initial begin
    int   n;
    logic saw;
    logic [31:0] base;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    chk("reset_armed", armed, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_attempt_cnt", attempt_cnt, 0);
    chk("reset_holdoff", holdoff, 0);
    chk("reset_pulse_width", pulse_width, 0);
    rst_n = 1'b1;
    cycle();

    // 1: 3x3 sweep, no trigger, with start->armed latency
    set_cfg(10, 30, 10, 1, 3, 1, 1, 2, 0);
    push_model(ho_start, ho_end, ho_step, pw_start, pw_end, pw_step, repeats);
    exp_done++;
    start = 1'b1; cycle(); start = 1'b0;
    chk("t1_busy_after_start", busy, 1);
    chk("t1_armed_one_cycle_after_start", armed, 0);
    cycle();
    chk("t1_armed_two_cycles_after_start", armed, 1);
    wait_idle("t1");
    chk("t1_final_attempt_cnt", attempt_cnt, 9);

    // 2: single point repeated three times
    set_cfg(5, 5, 1, 2, 2, 1, 3, 3, 0);
    run_sweep("t2");
    chk("t2_final_attempt_cnt", attempt_cnt, 3);

    // 3: trigger already high at start must fall and rise again
    trig_cmd = 1'b1;
    repeat (5) cycle();
    set_cfg(7, 7, 0, 4, 4, 0, 1, 1, 1);
    push_model(ho_start, ho_end, ho_step, pw_start, pw_end, pw_step, repeats);
    exp_done++;
    start = 1'b1; cycle(); start = 1'b0;
    saw = 0;
    repeat (10) begin cycle(); if (armed) saw = 1; end
    chk("t3_no_arm_while_trigger_high", saw, 0);
    trig_cmd = 1'b0;
    repeat (6) begin cycle(); if (armed) saw = 1; end
    chk("t3_no_arm_on_fall", saw, 0);
    trig_cmd = 1'b1;
    n = 0;
    while (!armed && n < 20) begin cycle(); n++; end
    chk("t3_edge_to_armed_cycles", 64'(n), 64'(SYNC + 2));
    wait_idle("t3");
    trig_cmd = 1'b0;

    // 4: holdoff step would carry past the top -> single holdoff point
    set_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 3, 3, 1, 1, 1, 0);
    run_sweep("t4");
    chk("t4_final_attempt_cnt", attempt_cnt, 1);

    // 5: abort while armed, then abort racing start in IDLE, then a fresh sweep
    rdy_mode = 1;
    set_cfg(32'h40, 32'h60, 32'h10, 9, 9, 0, 1, 2, 0);
    start = 1'b1; cycle(); start = 1'b0;
    n = 0;
    while (!armed && n < 20) begin cycle(); n++; end
    chk("t5_armed_before_abort", armed, 1);
    repeat (3) cycle();
    abort = 1'b1; cycle(); abort = 1'b0;
    chk("t5_armed_after_abort", armed, 0);
    chk("t5_busy_after_abort", busy, 0);
    chk("t5_holdoff_held", holdoff, 32'h40);
    chk("t5_pulse_width_held", pulse_width, 9);
    chk("t5_attempt_cnt_held", attempt_cnt, 0);
    rdy_mode = 0;
    repeat (4) cycle();
    start = 1'b1; abort = 1'b1; cycle(); start = 1'b0; abort = 1'b0;
    chk("t5_abort_beats_start_busy", busy, 0);
    cycle();
    chk("t5_abort_beats_start_armed", armed, 0);
    set_cfg(1, 2, 1, 8, 9, 1, 0, 0, 0);
    run_sweep("t5_restart");
    chk("t5_restart_attempt_cnt", attempt_cnt, 4);

    // 6: rdy stuck high after the first attempt holds the FSM in cooldown
    set_cfg(1, 1, 1, 1, 1, 1, 2, 2, 0);
    push_model(ho_start, ho_end, ho_step, pw_start, pw_end, pw_step, repeats);
    exp_done++;
    start = 1'b1; cycle(); start = 1'b0;
    n = 0;
    while (!attempt_stb && n < 50) begin cycle(); n++; end
    chk("t6_first_attempt_seen", attempt_stb, 1);
    rdy_mode = 2;
    saw = 0;
    repeat (20) begin cycle(); if (armed) saw = 1; end
    chk("t6_no_rearm_on_stuck_rdy", saw, 0);
    chk("t6_still_busy", busy, 1);
    rdy_mode = 0;
    wait_idle("t6");
    chk("t6_final_attempt_cnt", attempt_cnt, 2);

    // Random sweeps, including trigger use, near-top ranges and start>end
    trig_auto = 1'b1;
    for (int s = 0; s < 8; s++) begin
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 + $urandom_range(0, 31) : $urandom_range(0, 100);
      ho_start = base;
      ho_step  = $urandom_range(0, 6);
      ho_end   = ($urandom_range(0, 4) == 0) ? ho_start - 1 : ho_start + $urandom_range(0, 8);
      pw_start = $urandom_range(0, 50);
      pw_step  = $urandom_range(0, 4);
      pw_end   = ($urandom_range(0, 4) == 0) ? pw_start - 1 : pw_start + $urandom_range(0, 8);
      repeats  = $urandom_range(0, 3);
      cooldown = $urandom_range(0, 4);
      use_trigger = $urandom_range(0, 1);
      cur_cool = (cooldown == 0) ? 1 : int'(cooldown);
      run_sweep($sformatf("rand%0d", s));
    end
    trig_auto = 1'b0;

    repeat (5) cycle();
    chk("done_pulse_count", 64'(act_done), 64'(exp_done));
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
